// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, one shared 1-bit full adder stepped LSB-first.
// Revision 1.0
`default_nettype none

module full_adder_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_accept;
  logic             w_last;

  full_adder_1bit u_fa (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_cin (r_carry),
    .o_sum (w_fa_sum),
    .o_cout(w_fa_cout)
  );

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_cnt == c_last);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_res   <= {w_fa_sum, r_res[WIDTH-1:1]};
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_carry <= w_fa_cout;
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_res;
  assign cout      = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=2).
// Revision 1.0
`default_nettype none

module tb_serial_add_ctrl;
  logic       clock = 1'b0;
  logic       rstn;
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [7:0] a, b, sum;

  logic       v2_in_valid, v2_in_ready, v2_cin, v2_out_valid, v2_out_ready, v2_cout, v2_busy;
  logic [1:0] v2_a, v2_b, v2_sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clock(clock), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clock(clock), .rstn(rstn), .in_valid(v2_in_valid), .in_ready(v2_in_ready),
    .a(v2_a), .b(v2_b), .cin(v2_cin), .out_valid(v2_out_valid), .out_ready(v2_out_ready),
    .sum(v2_sum), .cout(v2_cout), .busy(v2_busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the WIDTH=8 instance; operands are scrambled after E0.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic [7:0] es, input logic ec);
    int lat;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = ~tc;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_done_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat, cyc, k, r;
    int acc_cyc [3];
    logic [7:0] op_a [3], op_b [3], ex_s [3];
    logic       op_c [3], ex_c [3];
    logic [2:0] ref2;

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    v2_in_valid = 1'b0; v2_out_ready = 1'b0; v2_a = '0; v2_b = '0; v2_cin = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);

    // Basic and wrap cases
    run_op("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: hold DONE for 5 cycles while hammering in_valid
    a = 8'h3C; b = 8'h0A; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("t3_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_sum", {24'd0, sum}, 32'h47);
      chk("t3_hold_cout", {31'd0, cout}, 32'd0);
      chk("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = i[0]; a = 8'h99; b = 8'h66; cin = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t3_release_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t3_no_ghost_busy", {31'd0, busy}, 32'd0);

    // Reset abort after bit 3 is resolved (edge E4)
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t4_busy_before_rst", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #2;
    chk("t4_rst_busy", {31'd0, busy}, 32'd0);
    chk("t4_rst_out_valid", {31'd0, out_valid}, 32'd0);
    #2;
    rstn = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) lat++;
    end
    chk("t4_no_out_valid", 32'(lat), 32'd0);
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    run_op("t4_after", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    op_a = '{8'h12, 8'h80, 8'h7F}; op_b = '{8'h34, 8'h80, 8'h01}; op_c = '{1'b0, 1'b1, 1'b1};
    ex_s = '{8'h46, 8'h01, 8'h81}; ex_c = '{1'b0, 1'b1, 1'b0};
    acc_cyc = '{0, 0, 0};
    out_ready = 1'b1;
    cyc = 0; k = 0; r = 0;
    while (r < 3 && cyc < 100) begin
      in_valid = (k < 3);
      if (in_ready && k < 3) begin
        a = op_a[k]; b = op_b[k]; cin = op_c[k];
        acc_cyc[k] = cyc;
        k++;
      end
      if (out_valid) begin
        chk("t5_sum", {24'd0, sum}, {24'd0, ex_s[r]});
        chk("t5_cout", {31'd0, cout}, {31'd0, ex_c[r]});
        r++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_results_seen", 32'(r), 32'd3);
    chk("t5_spacing_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
    chk("t5_spacing_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd10);
    tick();

    // WIDTH=2 exhaustive sweep against a+b+cin
    for (int x = 0; x < 32; x++) begin
      v2_a = x[1:0]; v2_b = x[3:2]; v2_cin = x[4];
      ref2 = {1'b0, v2_a} + {1'b0, v2_b} + {2'b00, v2_cin};
      v2_in_valid = 1'b1;
      chk("t6_in_ready", {31'd0, v2_in_ready}, 32'd1);
      tick();
      v2_in_valid = 1'b0;
      lat = 0;
      while (!v2_out_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk("t6_latency", 32'(lat), 32'd2);
      chk("t6_sum", {30'd0, v2_sum}, {30'd0, ref2[1:0]});
      chk("t6_cout", {31'd0, v2_cout}, {31'd0, ref2[2]});
      v2_out_ready = 1'b1;
      tick();
      v2_out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
